// File: rtl/multicycle_control_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_control_if : instruction/memory/datapath control bus  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface multicycle_control_if;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_src;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  wb_src;
  logic        alu_src_b;
  logic [2:0]  alu_ctrl;
  logic        retire;
  logic        illegal;
  logic        timeout;

  modport master (
    input  instr, mem_ready, alu_zero,
    output mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           reg_write, wb_src, alu_src_b, alu_ctrl, retire, illegal, timeout
  );

  modport slave (
    output instr, mem_ready, alu_zero,
    input  mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
           reg_write, wb_src, alu_src_b, alu_ctrl, retire, illegal, timeout
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multicycle_control : FSM sequencing fetch/decode/exec/mem/wb     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module multicycle_control #(
  parameter int IMM_OPS = 1,
  parameter int JAL_EN  = 1,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 rstn,
  multicycle_control_if.master bus
);

  localparam int                 c_cnt_w     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  state_t              r_state, w_next;
  logic [c_cnt_w-1:0]  r_wait;
  logic                r_illegal, r_timeout;

  logic [6:0] w_opcode, w_funct7;
  logic [2:0] w_funct3, w_logic_op;
  logic       w_is_r, w_is_i, w_is_ld, w_is_sd, w_is_beq, w_is_jal, w_legal;
  logic       w_in_mem, w_expire, w_f3_ok;
  logic       w_unused;

  assign w_opcode = bus.instr[6:0];
  assign w_funct3 = bus.instr[14:12];
  assign w_funct7 = bus.instr[31:25];
  assign w_unused = ^{bus.instr[24:15], bus.instr[11:7]};

  assign w_f3_ok  = (w_funct3 == 3'd0) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
  assign w_is_r   = (w_opcode == 7'd51) && w_f3_ok &&
                    ((w_funct3 != 3'd0) || (w_funct7 == 7'd0) || (w_funct7 == 7'd32));
  assign w_is_i   = (IMM_OPS != 0) && (w_opcode == 7'd19) && w_f3_ok;
  assign w_is_ld  = (w_opcode == 7'd3)  && (w_funct3 == 3'd3);
  assign w_is_sd  = (w_opcode == 7'd35) && (w_funct3 == 3'd3);
  assign w_is_beq = (w_opcode == 7'd99) && (w_funct3 == 3'd0);
  assign w_is_jal = (JAL_EN != 0) && (w_opcode == 7'd111);
  assign w_legal  = w_is_r | w_is_i | w_is_ld | w_is_sd | w_is_beq | w_is_jal;

  // funct3 7 -> and, 6 -> or, 0 -> add (sub override handled for R-type)
  assign w_logic_op = (w_funct3 == 3'd7) ? 3'b000 :
                      (w_funct3 == 3'd6) ? 3'b001 : 3'b010;

  assign w_in_mem = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_expire = (TIMEOUT != 0) && w_in_mem && !bus.mem_ready && (r_wait == c_wait_last);

  always_comb begin
    w_next            = r_state;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr_src  = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.wb_src        = 2'b00;
    bus.alu_src_b     = 1'b0;
    bus.alu_ctrl      = 3'b010;
    bus.retire        = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.alu_ctrl = 3'b000;
        w_next       = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (w_expire) begin
          w_next = S_TRAP;
        end else if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          w_next       = S_DECODE;
        end
      end
      S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_r) begin
          bus.alu_ctrl = ((w_funct3 == 3'd0) && (w_funct7 == 7'd32)) ? 3'b110 : w_logic_op;
          w_next       = S_WB;
        end else if (w_is_i) begin
          bus.alu_src_b = 1'b1;
          bus.alu_ctrl  = w_logic_op;
          w_next        = S_WB;
        end else if (w_is_ld || w_is_sd) begin
          bus.alu_src_b = 1'b1;
          w_next        = S_MEM;
        end else if (w_is_beq) begin
          bus.alu_ctrl = 3'b110;
          bus.pc_write = bus.alu_zero;
          bus.pc_src   = 2'b01;
          bus.retire   = 1'b1;
          w_next       = S_FETCH;
        end else begin
          bus.pc_write  = 1'b1;
          bus.pc_src    = 2'b10;
          bus.reg_write = 1'b1;
          bus.wb_src    = 2'b10;
          bus.retire    = 1'b1;
          w_next        = S_FETCH;
        end
      end
      S_MEM: begin
        bus.mem_req      = 1'b1;
        bus.mem_addr_src = 1'b1;
        bus.mem_we       = w_is_sd;
        if (w_expire) begin
          w_next = S_TRAP;
        end else if (bus.mem_ready) begin
          bus.retire = w_is_sd;
          w_next     = w_is_sd ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        bus.reg_write = 1'b1;
        bus.wb_src    = w_is_ld ? 2'b01 : 2'b00;
        bus.retire    = 1'b1;
        w_next        = S_FETCH;
      end
      S_TRAP:  bus.alu_ctrl = 3'b000;
      default: begin
        bus.alu_ctrl = 3'b000;
        w_next       = S_IDLE;
      end
    endcase
  end

  assign bus.illegal = r_illegal;
  assign bus.timeout = r_timeout;

  // Counter idles at zero outside FETCH/MEM, so every entry starts clean.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_in_mem && !bus.mem_ready) ? r_wait + c_cnt_one : '0;
      if ((r_state == S_DECODE) && !w_legal) r_illegal <= 1'b1;
      if (w_expire) r_timeout <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// Scoreboard bench: stimulus queues per-cycle expected control vectors,
// a negedge monitor pops and compares them against the selected DUT.
module tb_multicycle_control;

  localparam logic [31:0] c_add  = 32'h002081B3;
  localparam logic [31:0] c_sub  = 32'h402081B3;
  localparam logic [31:0] c_and  = 32'h0020F1B3;
  localparam logic [31:0] c_ori  = 32'h0010E093;
  localparam logic [31:0] c_addi = 32'h00108093;
  localparam logic [31:0] c_ld   = 32'h0080B283;
  localparam logic [31:0] c_sd   = 32'h0020B823;
  localparam logic [31:0] c_beq  = 32'h00208463;
  localparam logic [31:0] c_jal  = 32'h0000006F;
  localparam logic [31:0] c_bad  = 32'h202081B3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr_d;
  logic        ready_d, zero_d;

  multicycle_control_if ifa ();
  multicycle_control_if ifb ();

  assign ifa.instr     = instr_d;
  assign ifa.mem_ready = ready_d;
  assign ifa.alu_zero  = zero_d;
  assign ifb.instr     = instr_d;
  assign ifb.mem_ready = ready_d;
  assign ifb.alu_zero  = zero_d;

  multicycle_control #(.IMM_OPS(1), .JAL_EN(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa));
  multicycle_control #(.IMM_OPS(0), .JAL_EN(0), .TIMEOUT(0)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb));

  always #5 clk = ~clk;

  logic [16:0] act_a, act_b;
  assign act_a = {ifa.mem_req, ifa.mem_we, ifa.mem_addr_src, ifa.ir_write, ifa.pc_write,
                  ifa.pc_src, ifa.reg_write, ifa.wb_src, ifa.alu_src_b, ifa.alu_ctrl,
                  ifa.retire, ifa.illegal, ifa.timeout};
  assign act_b = {ifb.mem_req, ifb.mem_we, ifb.mem_addr_src, ifb.ir_write, ifb.pc_write,
                  ifb.pc_src, ifb.reg_write, ifb.wb_src, ifb.alu_src_b, ifb.alu_ctrl,
                  ifb.retire, ifb.illegal, ifb.timeout};

  logic [16:0] q_exp[$];
  bit          q_sel[$];
  string       q_tag[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [16:0] mk(input logic req, we, asrc, irw, pcw,
                                     input logic [1:0] pcs, input logic regw,
                                     input logic [1:0] wbs, input logic bsrc,
                                     input logic [2:0] alu, input logic ret, ill, to);
    return {req, we, asrc, irw, pcw, pcs, regw, wbs, bsrc, alu, ret, ill, to};
  endfunction

  always @(negedge clk) begin
    logic [16:0] e, a;
    bit          s;
    string       t;
    if (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      s = q_sel.pop_front();
      t = q_tag.pop_front();
      a = s ? act_b : act_a;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s dut%0d got %05h expected %05h", t, s, a, e);
      end
    end
  end

  task automatic step(input logic [31:0] ins, input logic rdy, input logic z, input logic r,
                      input bit sel, input logic [16:0] exp, input string tag);
    @(posedge clk);
    #1;
    rstn    = r;
    instr_d = ins;
    ready_d = rdy;
    zero_d  = z;
    q_exp.push_back(exp);
    q_sel.push_back(sel);
    q_tag.push_back(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e_zero, e_fwait, e_fdone, e_dec, e_imm, e_wb_alu, e_wb_mem;
    logic [16:0] e_mem_rd, e_mem_wr, e_ill, e_to;
    rstn = 1'b0; instr_d = '0; ready_d = 1'b0; zero_d = 1'b0;
    e_zero   = '0;
    e_fwait  = mk(1,0,0,0,0,2'b00,0,2'b00,0,3'b010,0,0,0);
    e_fdone  = mk(1,0,0,1,1,2'b00,0,2'b00,0,3'b010,0,0,0);
    e_dec    = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b010,0,0,0);
    e_imm    = mk(0,0,0,0,0,2'b00,0,2'b00,1,3'b010,0,0,0);
    e_wb_alu = mk(0,0,0,0,0,2'b00,1,2'b00,0,3'b010,1,0,0);
    e_wb_mem = mk(0,0,0,0,0,2'b00,1,2'b01,0,3'b010,1,0,0);
    e_mem_rd = mk(1,0,1,0,0,2'b00,0,2'b00,0,3'b010,0,0,0);
    e_mem_wr = mk(1,1,1,0,0,2'b00,0,2'b00,0,3'b010,0,0,0);
    e_ill    = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,1,0);
    e_to     = mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0,1);

    step(c_add, 1, 0, 0, 0, e_zero,   "in_reset");
    step(c_add, 1, 0, 1, 0, e_zero,   "idle");
    step(c_add, 1, 0, 1, 0, e_fdone,  "add_fetch");
    step(c_add, 1, 0, 1, 0, e_dec,    "add_decode");
    step(c_add, 1, 0, 1, 0, e_dec,    "add_exec");
    step(c_add, 1, 0, 1, 0, e_wb_alu, "add_wb");

    step(c_ld, 1, 0, 1, 0, e_fdone,  "ld_fetch");
    step(c_ld, 1, 0, 1, 0, e_dec,    "ld_decode");
    step(c_ld, 1, 0, 1, 0, e_imm,    "ld_exec");
    step(c_ld, 0, 0, 1, 0, e_mem_rd, "ld_mem_wait1");
    step(c_ld, 0, 0, 1, 0, e_mem_rd, "ld_mem_wait2");
    step(c_ld, 1, 0, 1, 0, e_mem_rd, "ld_mem_done");
    step(c_ld, 1, 0, 1, 0, e_wb_mem, "ld_wb");

    step(c_sub, 1, 0, 1, 0, e_fdone,  "sub_fetch");
    step(c_sub, 1, 0, 1, 0, e_dec,    "sub_decode");
    step(c_sub, 1, 0, 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b110,0,0,0), "sub_exec");
    step(c_sub, 1, 0, 1, 0, e_wb_alu, "sub_wb");

    step(c_and, 1, 0, 1, 0, e_fdone,  "and_fetch");
    step(c_and, 1, 0, 1, 0, e_dec,    "and_decode");
    step(c_and, 1, 0, 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,0,3'b000,0,0,0), "and_exec");
    step(c_and, 1, 0, 1, 0, e_wb_alu, "and_wb");

    step(c_ori, 1, 0, 1, 0, e_fdone,  "ori_fetch");
    step(c_ori, 1, 0, 1, 0, e_dec,    "ori_decode");
    step(c_ori, 1, 0, 1, 0, mk(0,0,0,0,0,2'b00,0,2'b00,1,3'b001,0,0,0), "ori_exec");
    step(c_ori, 1, 0, 1, 0, e_wb_alu, "ori_wb");

    step(c_beq, 1, 1, 1, 0, e_fdone, "beq_t_fetch");
    step(c_beq, 1, 1, 1, 0, e_dec,   "beq_t_decode");
    step(c_beq, 1, 1, 1, 0, mk(0,0,0,0,1,2'b01,0,2'b00,0,3'b110,1,0,0), "beq_taken_exec");
    step(c_beq, 1, 0, 1, 0, e_fdone, "beq_n_fetch");
    step(c_beq, 1, 0, 1, 0, e_dec,   "beq_n_decode");
    step(c_beq, 1, 0, 1, 0, mk(0,0,0,0,0,2'b01,0,2'b00,0,3'b110,1,0,0), "beq_not_exec");

    step(c_sd, 1, 0, 1, 0, e_fdone, "sd_fetch");
    step(c_sd, 1, 0, 1, 0, e_dec,   "sd_decode");
    step(c_sd, 1, 0, 1, 0, e_imm,   "sd_exec");
    step(c_sd, 1, 0, 1, 0, mk(1,1,1,0,0,2'b00,0,2'b00,0,3'b010,1,0,0), "sd_mem_done");

    step(c_jal, 1, 0, 1, 0, e_fdone, "jal_fetch");
    step(c_jal, 1, 0, 1, 0, e_dec,   "jal_decode");
    step(c_jal, 1, 0, 1, 0, mk(0,0,0,0,1,2'b10,1,2'b10,0,3'b010,1,0,0), "jal_exec");

    step(c_bad, 1, 0, 1, 0, e_fdone, "bad_fetch");
    step(c_bad, 1, 0, 1, 0, e_dec,   "bad_decode");
    for (int i = 0; i < 3; i++) step(c_bad, 1, 1, 1, 0, e_ill, "bad_trap_hold");

    step(c_ld, 0, 0, 0, 0, e_zero, "to_reset");
    step(c_ld, 0, 0, 1, 0, e_zero, "to_idle");
    for (int i = 0; i < 4; i++) step(c_ld, 0, 0, 1, 0, e_fwait, "to_fetch_wait");
    step(c_ld, 1, 0, 1, 0, e_to, "to_trap");
    step(c_ld, 1, 0, 1, 0, e_to, "to_trap_hold");

    step(c_sd, 1, 0, 0, 0, e_zero,   "ar_reset");
    step(c_sd, 1, 0, 1, 0, e_zero,   "ar_idle");
    step(c_sd, 1, 0, 1, 0, e_fdone,  "ar_sd_fetch");
    step(c_sd, 1, 0, 1, 0, e_dec,    "ar_sd_decode");
    step(c_sd, 1, 0, 1, 0, e_imm,    "ar_sd_exec");
    step(c_sd, 0, 0, 1, 0, e_mem_wr, "ar_sd_mem_wait");
    step(c_sd, 0, 0, 0, 0, e_zero,   "ar_async_drop");
    step(c_ld, 0, 0, 1, 0, e_zero,   "ar_restart_idle");
    for (int i = 0; i < 3; i++) step(c_ld, 0, 0, 1, 0, e_fwait, "ar_fetch_wait3");
    step(c_ld, 1, 0, 1, 0, e_fdone,  "ar_fetch_late_ok");
    step(c_ld, 1, 0, 1, 0, e_dec,    "ar_ld_decode");
    step(c_ld, 1, 0, 1, 0, e_imm,    "ar_ld_exec");
    for (int i = 0; i < 4; i++) step(c_ld, 0, 0, 1, 0, e_mem_rd, "mem_to_wait");
    step(c_ld, 0, 0, 1, 0, e_to, "mem_to_trap");

    step(c_jal, 1, 0, 0, 1, e_zero,  "b_reset1");
    step(c_jal, 1, 0, 1, 1, e_zero,  "b_idle1");
    step(c_jal, 1, 0, 1, 1, e_fdone, "b_jal_fetch");
    step(c_jal, 1, 0, 1, 1, e_dec,   "b_jal_decode");
    step(c_jal, 1, 0, 1, 1, e_ill,   "b_jal_illegal");
    step(c_addi, 1, 0, 0, 1, e_zero,  "b_reset2");
    step(c_addi, 1, 0, 1, 1, e_zero,  "b_idle2");
    step(c_addi, 1, 0, 1, 1, e_fdone, "b_addi_fetch");
    step(c_addi, 1, 0, 1, 1, e_dec,   "b_addi_decode");
    step(c_addi, 1, 0, 1, 1, e_ill,   "b_addi_illegal");
    step(c_add, 0, 0, 0, 1, e_zero,  "b_reset3");
    step(c_add, 0, 0, 1, 1, e_zero,  "b_idle3");
    for (int i = 0; i < 20; i++) step(c_add, 0, 0, 1, 1, e_fwait, "b_no_timeout_wait");
    step(c_add, 1, 0, 1, 1, e_fdone, "b_late_fetch");
    step(c_add, 1, 0, 1, 1, e_dec,   "b_add_decode");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q_exp.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
